// File: rtl/fetch_pc_unit_if.sv
// Bundle between the fetch PC unit and its neighbours: icache, branch
// predictor, execute redirect and the IF/ID output stage.
interface fetch_pc_unit_if;
    logic        ihit;
    logic [31:0] iload;
    logic        take_br;
    logic [31:0] br_target;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        iREN;
    logic [31:0] iaddr;
    logic [1:0]  r_index;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_npc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        halted;

    modport master (
        input  ihit, iload, take_br, br_target, stall, redirect, redirect_pc,
        output iREN, iaddr, r_index, if_valid, if_instr, if_pc, if_npc,
               if_pred_taken, if_pred_target, halted
    );

    modport slave (
        output ihit, iload, take_br, br_target, stall, redirect, redirect_pc,
        input  iREN, iaddr, r_index, if_valid, if_instr, if_pc, if_npc,
               if_pred_taken, if_pred_target, halted
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, requests the icache, consults the
// branch predictor and holds one fetched instruction for the IF/ID latch.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    fetch_pc_unit_if.master   bus
);

    typedef enum logic {FETCH, HALTED} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_en;
    logic        accept;
    logic        is_halt;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_npc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;

    assign pc_plus4 = pc + 32'd4;
    assign is_halt  = (bus.iload[31:26] == 6'b111111);

    always_ff @(posedge CLK) begin
        if (RST) state <= FETCH;
        else     state <= next_state;
    end

    // No path from ihit into iREN: the request only depends on state, stall and redirect.
    always_comb begin
        next_state = state;
        fetch_en   = !RST && (state == FETCH) && !bus.redirect && (!if_valid || !bus.stall);
        accept     = fetch_en && bus.ihit;
        if (bus.redirect)
            next_state = FETCH;
        else if (accept && is_halt)
            next_state = HALTED;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc             <= RESET_PC & ~32'h3;
            if_valid       <= 1'b0;
            if_instr       <= '0;
            if_pc          <= '0;
            if_npc         <= '0;
            if_pred_taken  <= 1'b0;
            if_pred_target <= '0;
        end else if (bus.redirect) begin
            pc       <= bus.redirect_pc & ~32'h3;
            if_valid <= 1'b0;
        end else if (accept) begin
            if_valid       <= 1'b1;
            if_instr       <= bus.iload;
            if_pc          <= pc;
            if_npc         <= pc_plus4;
            if_pred_taken  <= bus.take_br;
            if_pred_target <= bus.br_target & ~32'h3;
            pc             <= bus.take_br ? (bus.br_target & ~32'h3) : pc_plus4;
        end else if (if_valid && !bus.stall) begin
            if_valid <= 1'b0;
        end
    end

    assign bus.iREN           = fetch_en;
    assign bus.iaddr          = pc;
    assign bus.r_index        = pc[3:2];
    assign bus.halted         = !RST && (state == HALTED);
    assign bus.if_valid       = if_valid;
    assign bus.if_instr       = if_instr;
    assign bus.if_pc          = if_pc;
    assign bus.if_npc         = if_npc;
    assign bus.if_pred_taken  = if_pred_taken;
    assign bus.if_pred_target = if_pred_target;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: each task drives one scenario and checks
// hand-computed values inline.
module tb_fetch_pc_unit;

    logic CLK;
    logic RST;
    int   tests_run;
    int   tests_failed;

    fetch_pc_unit_if bus();

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock and settle just past the rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.ihit = 1'b1; bus.iload = 32'h1111_1111; bus.take_br = 1'b0;
        bus.br_target = '0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        cyc(); cyc();
        tests_run++;
        if (bus.iREN !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_iren got %b want 0", bus.iREN); end
        tests_run++;
        if (bus.if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b want 0", bus.if_valid); end
        tests_run++;
        if (bus.halted !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_halted got %b want 0", bus.halted); end
        tests_run++;
        if (bus.iaddr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_iaddr got %h want 0", bus.iaddr); end
        RST = 1'b0;
        #1;
        tests_run++;
        if (bus.iREN !== 1'b1) begin tests_failed++; $display("[TB] FAIL first_iren got %b want 1", bus.iREN); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(4 * i);
            bus.ihit = 1'b1; bus.take_br = 1'b0; bus.iload = 32'h1000_0000 + 32'(i);
            #1;
            tests_run++;
            if (bus.iaddr !== exp_pc || bus.r_index !== exp_pc[3:2] || bus.iREN !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL seq_req%0d got iaddr=%h idx=%0d ren=%b want iaddr=%h idx=%0d ren=1",
                         i, bus.iaddr, bus.r_index, bus.iREN, exp_pc, exp_pc[3:2]);
            end
            cyc();
            tests_run++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc || bus.if_npc !== exp_pc + 32'd4 ||
                bus.if_instr !== 32'h1000_0000 + 32'(i)) begin
                tests_failed++;
                $display("[TB] FAIL seq_out%0d got v=%b pc=%h npc=%h instr=%h want v=1 pc=%h npc=%h",
                         i, bus.if_valid, bus.if_pc, bus.if_npc, bus.if_instr, exp_pc, exp_pc + 32'd4);
            end
        end
    endtask

    task automatic test_branch();
        bus.take_br = 1'b1; bus.br_target = 32'h0000_0042; bus.iload = 32'h2222_0000;
        #1;
        tests_run++;
        if (bus.iaddr !== 32'h10) begin tests_failed++; $display("[TB] FAIL br_pc got %h want 10", bus.iaddr); end
        cyc();
        bus.take_br = 1'b0;
        tests_run++;
        if (bus.iaddr !== 32'h40) begin tests_failed++; $display("[TB] FAIL br_next got %h want 40", bus.iaddr); end
        tests_run++;
        if (bus.if_pred_taken !== 1'b1 || bus.if_pred_target !== 32'h40 || bus.if_npc !== 32'h14 || bus.if_pc !== 32'h10) begin
            tests_failed++;
            $display("[TB] FAIL br_out got taken=%b tgt=%h npc=%h pc=%h want 1 40 14 10",
                     bus.if_pred_taken, bus.if_pred_target, bus.if_npc, bus.if_pc);
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1; bus.ihit = 1'b1; bus.iload = 32'h3333_0000;
        #1;
        tests_run++;
        if (bus.iREN !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_iren got %b want 0", bus.iREN); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests_run++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h10 || bus.if_instr !== 32'h2222_0000 ||
                bus.iaddr !== 32'h40 || bus.iREN !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d got v=%b pc=%h instr=%h iaddr=%h ren=%b want 1 10 22220000 40 0",
                         i, bus.if_valid, bus.if_pc, bus.if_instr, bus.iaddr, bus.iREN);
            end
        end
        bus.stall = 1'b0;
        #1;
        tests_run++;
        if (bus.iREN !== 1'b1) begin tests_failed++; $display("[TB] FAIL unstall_iren got %b want 1", bus.iREN); end
        cyc();
        tests_run++;
        if (bus.if_pc !== 32'h40 || bus.if_instr !== 32'h3333_0000 || bus.iaddr !== 32'h44) begin
            tests_failed++;
            $display("[TB] FAIL unstall_out got pc=%h instr=%h iaddr=%h want 40 33330000 44",
                     bus.if_pc, bus.if_instr, bus.iaddr);
        end
    endtask

    task automatic test_redirect();
        bus.stall = 1'b1; bus.ihit = 1'b1; bus.iload = 32'hDEAD_0000;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0201;
        #1;
        tests_run++;
        if (bus.iREN !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_iren got %b want 0", bus.iREN); end
        cyc();
        bus.redirect = 1'b0; bus.stall = 1'b0; bus.iload = 32'h4444_0000;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.iaddr !== 32'h200) begin
            tests_failed++;
            $display("[TB] FAIL redir_next got v=%b iaddr=%h want 0 200", bus.if_valid, bus.iaddr);
        end
        cyc();
        tests_run++;
        if (bus.if_pc !== 32'h200 || bus.if_instr !== 32'h4444_0000) begin
            tests_failed++;
            $display("[TB] FAIL redir_first got pc=%h instr=%h want 200 44440000", bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_halt();
        bus.ihit = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h30;
        cyc();
        bus.redirect = 1'b0; bus.ihit = 1'b1; bus.iload = 32'hFC00_0000;
        cyc();
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h30 || bus.if_instr !== 32'hFC00_0000) begin
            tests_failed++;
            $display("[TB] FAIL halt_deliver got v=%b pc=%h instr=%h want 1 30 fc000000",
                     bus.if_valid, bus.if_pc, bus.if_instr);
        end
        tests_run++;
        if (bus.halted !== 1'b1 || bus.iREN !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL halt_state got halted=%b ren=%b want 1 0", bus.halted, bus.iREN);
        end
        cyc();
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.iaddr !== 32'h34 || bus.halted !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL halt_drain got v=%b iaddr=%h halted=%b want 0 34 1",
                     bus.if_valid, bus.iaddr, bus.halted);
        end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
        cyc();
        bus.redirect = 1'b0; bus.iload = 32'h5555_0000;
        #1;
        tests_run++;
        if (bus.halted !== 1'b0 || bus.iaddr !== 32'h80 || bus.iREN !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL halt_resume got halted=%b iaddr=%h ren=%b want 0 80 1",
                     bus.halted, bus.iaddr, bus.iREN);
        end
        cyc();
        tests_run++;
        if (bus.if_pc !== 32'h80 || bus.if_instr !== 32'h5555_0000) begin
            tests_failed++;
            $display("[TB] FAIL halt_refetch got pc=%h instr=%h want 80 55550000", bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_wrap_and_reset();
        bus.ihit = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        cyc();
        bus.redirect = 1'b0; bus.ihit = 1'b1; bus.take_br = 1'b0;
        bus.br_target = 32'h1234_5678; bus.iload = 32'h6666_0000;
        cyc();
        tests_run++;
        if (bus.if_pc !== 32'hFFFF_FFFC || bus.if_npc !== 32'h0 || bus.iaddr !== 32'h0 ||
            bus.if_pred_taken !== 1'b0 || bus.if_pred_target !== 32'h1234_5678) begin
            tests_failed++;
            $display("[TB] FAIL wrap got pc=%h npc=%h iaddr=%h taken=%b tgt=%h want fffffffc 0 0 0 12345678",
                     bus.if_pc, bus.if_npc, bus.iaddr, bus.if_pred_taken, bus.if_pred_target);
        end
        bus.stall = 1'b1;
        cyc();
        RST = 1'b1;
        #1;
        tests_run++;
        if (bus.iREN !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_iren got %b want 0", bus.iREN); end
        cyc();
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_npc !== 32'h0 ||
            bus.if_pred_taken !== 1'b0 || bus.if_pred_target !== 32'h0 || bus.iaddr !== 32'h0 || bus.halted !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid got v=%b instr=%h pc=%h npc=%h taken=%b tgt=%h iaddr=%h halted=%b want all zero",
                     bus.if_valid, bus.if_instr, bus.if_pc, bus.if_npc, bus.if_pred_taken,
                     bus.if_pred_target, bus.iaddr, bus.halted);
        end
        RST = 1'b0; bus.stall = 1'b0;
        #1;
        tests_run++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL rst_restart got ren=%b iaddr=%h want 1 0", bus.iREN, bus.iaddr);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
